// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and the IF/ID pipeline register.
// Handles stalls, EX-stage redirects, and a halt address that drains the pipe.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] HALT_PC  = 32'h0000_0400,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] inst_in,
  output logic [31:0] PC_out,
  output logic        IF_ID_valid,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Inst,
  output logic [31:0] fetch_cnt,
  output logic        misalign_err,
  output logic        halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= NOP_INST;
      cnt_q      <= 32'h0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      cnt_q      <= cnt_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    cnt_d      = cnt_q;
    mis_d      = mis_q;

    if (redirect) begin
      // A redirect flushes IF/ID even when a stall is asserted alongside it.
      state_d    = ST_RUN;
      pc_d       = word_align(redirect_pc);
      id_valid_d = 1'b0;
      id_pc_d    = 32'h0;
      id_inst_d  = NOP_INST;
      if (redirect_pc[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!stall) begin
            if (pc_q == HALT_PC) begin
              state_d    = ST_HALT;
              id_valid_d = 1'b0;
              id_pc_d    = 32'h0;
              id_inst_d  = NOP_INST;
            end else begin
              id_valid_d = 1'b1;
              id_pc_d    = pc_q;
              id_inst_d  = inst_in;
              pc_d       = pc_q + 32'd4;
              cnt_d      = sat_inc(cnt_q);
            end
          end
        end
        ST_HALT: begin
          // Keep injecting bubbles so the downstream pipe drains; stall is moot.
          id_valid_d = 1'b0;
          id_pc_d    = 32'h0;
          id_inst_d  = NOP_INST;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign PC_out       = pc_q;
  assign IF_ID_valid  = id_valid_q;
  assign IF_ID_PC     = id_pc_q;
  assign IF_ID_Inst   = id_inst_q;
  assign fetch_cnt    = cnt_q;
  assign misalign_err = mis_q;
  assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] HPC = 32'h0000_0400;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_in;
  logic [31:0] PC_out;
  logic        IF_ID_valid;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Inst;
  logic [31:0] fetch_cnt;
  logic        misalign_err;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ifpc, m_inst, m_cnt;
  logic        m_valid, m_mis, m_halt;

  fetch_stage dut (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_in(inst_in), .PC_out(PC_out),
    .IF_ID_valid(IF_ID_valid), .IF_ID_PC(IF_ID_PC), .IF_ID_Inst(IF_ID_Inst),
    .fetch_cnt(fetch_cnt), .misalign_err(misalign_err), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign inst_in = rom(PC_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pc"},     PC_out,       m_pc);
    chk({tag, ".valid"},  {31'b0, IF_ID_valid},  {31'b0, m_valid});
    chk({tag, ".ifpc"},   IF_ID_PC,     m_ifpc);
    chk({tag, ".inst"},   IF_ID_Inst,   m_inst);
    chk({tag, ".cnt"},    fetch_cnt,    m_cnt);
    chk({tag, ".mis"},    {31'b0, misalign_err}, {31'b0, m_mis});
    chk({tag, ".halted"}, {31'b0, halted},       {31'b0, m_halt});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_inst = NOP; m_cnt = 32'h0;
    m_valid = 1'b0; m_mis = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit r, input logic [31:0] rpc);
    if (r) begin
      m_pc = rpc & ~32'd3;
      m_valid = 1'b0; m_ifpc = 32'h0; m_inst = NOP; m_halt = 1'b0;
      if (rpc % 4 != 0) m_mis = 1'b1;
    end else if (m_halt) begin
      m_valid = 1'b0; m_ifpc = 32'h0; m_inst = NOP;
    end else if (s) begin
      // everything holds
    end else if (m_pc == HPC) begin
      m_halt = 1'b1; m_valid = 1'b0; m_ifpc = 32'h0; m_inst = NOP;
    end else begin
      m_valid = 1'b1; m_ifpc = m_pc; m_inst = rom(m_pc);
      m_pc = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  // Drive inputs away from the edge, advance one clock, then compare.
  task automatic step(input bit s, input bit r, input logic [31:0] rpc, input string tag);
    stall = s; redirect = r; redirect_pc = rpc;
    model_step(s, r, rpc);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rstn = 1'b0;
    #2;
    model_reset();
    compare_all(tag);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(posedge clk); #1;

    // Reset state and four free-running fetches
    do_reset("rst0");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, "run4");
    chk("run4.pc_final", PC_out, 32'h10);
    chk("run4.cnt_final", fetch_cnt, 32'd4);
    chk("run4.ifpc_final", IF_ID_PC, 32'hC);
    chk("run4.inst_final", IF_ID_Inst, 32'h1000_0003);

    // Stall at PC 0x8
    do_reset("rst1");
    step(1'b0, 1'b0, 32'h0, "pre_stall");
    step(1'b0, 1'b0, 32'h0, "pre_stall");
    step(1'b1, 1'b0, 32'h0, "stall");
    step(1'b1, 1'b0, 32'h0, "stall");
    chk("stall.pc_held", PC_out, 32'h8);
    chk("stall.ifpc_held", IF_ID_PC, 32'h4);
    chk("stall.cnt_held", fetch_cnt, 32'd2);
    step(1'b0, 1'b0, 32'h0, "unstall");
    chk("unstall.ifpc", IF_ID_PC, 32'h8);

    // Redirect together with stall at PC 0x10
    step(1'b0, 1'b0, 32'h0, "to10");
    chk("to10.pc", PC_out, 32'h10);
    step(1'b1, 1'b1, 32'h40, "redir_stall");
    chk("redir_stall.pc", PC_out, 32'h40);
    chk("redir_stall.inst", IF_ID_Inst, NOP);
    step(1'b0, 1'b0, 32'h0, "after_redir");
    chk("after_redir.ifpc", IF_ID_PC, 32'h40);

    // Misaligned redirect, sticky through clean redirects until reset
    step(1'b0, 1'b1, 32'h42, "misalign");
    chk("misalign.pc", PC_out, 32'h40);
    chk("misalign.flag", {31'b0, misalign_err}, 32'd1);
    step(1'b0, 1'b0, 32'h0, "mis_run");
    step(1'b0, 1'b1, 32'h80, "mis_clean");
    chk("mis_clean.flag", {31'b0, misalign_err}, 32'd1);

    // PC wraparound at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFF8, "wrap_redir");
    step(1'b0, 1'b0, 32'h0, "wrap");
    step(1'b0, 1'b0, 32'h0, "wrap");
    chk("wrap.pc", PC_out, 32'h0);
    chk("wrap.ifpc", IF_ID_PC, 32'hFFFF_FFFC);

    // Sequential run to the halt address
    do_reset("rst2");
    chk("rst2.mis_cleared", {31'b0, misalign_err}, 32'd0);
    for (int i = 0; i < 256; i++) step(1'b0, 1'b0, 32'h0, "seq");
    chk("seq.pc", PC_out, HPC);
    chk("seq.cnt", fetch_cnt, 32'd256);
    for (int i = 0; i < 4; i++) step(i[0], 1'b0, 32'h0, "halt");
    chk("halt.flag", {31'b0, halted}, 32'd1);
    chk("halt.pc", PC_out, HPC);
    chk("halt.valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("halt.cnt", fetch_cnt, 32'd256);
    step(1'b0, 1'b1, 32'h3F0, "halt_redir");
    chk("halt_redir.flag", {31'b0, halted}, 32'd0);
    chk("halt_redir.pc", PC_out, 32'h3F0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, "rehalt");
    chk("rehalt.flag", {31'b0, halted}, 32'd1);

    // Random traffic
    do_reset("rst3");
    for (int i = 0; i < 400; i++) begin
      bit s, r;
      logic [31:0] rpc;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      rpc = {20'h0, 2'($urandom_range(0, 1)), 10'($urandom)};
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step(s, r, rpc, "rand");
    end

    // Asynchronous reset mid-cycle at PC 0x20
    do_reset("rst4");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, "pre_async");
    chk("pre_async.pc", PC_out, 32'h20);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    chk("async_rst.pc", PC_out, 32'h0);
    chk("async_rst.inst", IF_ID_Inst, NOP);
    #3;
    rstn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
